// File: rtl/alu_exec_ctrl.sv
// Multi-cycle execute-stage sequencer for the 16-bit ALU: decode, operand fetch, PSR, writeback,
// PC redirect and LOAD/STORE sequencing. Optional macro ALU_EXEC_ILLEGAL_TRAP_EN adds illegal_op.
module alu_exec_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] pc,
    output logic [3:0]  rf_raddr_a,
    output logic [3:0]  rf_raddr_b,
    input  logic [15:0] rf_rdata_a,
    input  logic [15:0] rf_rdata_b,
    output logic        rf_we,
    output logic [3:0]  rf_waddr,
    output logic [15:0] rf_wdata,
    output logic [15:0] alu_dst,
    output logic [15:0] alu_src,
    output logic [3:0]  alu_oper,
    output logic [3:0]  alu_func,
    output logic [3:0]  alu_cond,
    output logic [4:0]  alu_psr_read,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_psr_write,
    input  logic [4:0]  alu_psr_wr_en,
    output logic [4:0]  psr,
    output logic        pc_load,
    output logic [15:0] pc_next,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_err
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
    ,
    output logic        illegal_op
`endif
);

    typedef enum logic [1:0] {StIdle, StDecode, StExec, StMem} state_e;

    localparam logic [3:0] OpReg     = 4'b0000;
    localparam logic [3:0] OpSpecial = 4'b0100;
    localparam logic [3:0] OpShift   = 4'b1000;
    localparam logic [3:0] OpBcond   = 4'b1100;
    localparam logic [7:0] TimeoutCnt = 8'(MEM_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] instr_q, pc_q, dst_q, src_q;
    logic [4:0]  psr_q, psr_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [3:0]  oper, func, rd_f, rs_f;
    logic [15:0] src_dec;
    logic        illegal, no_wb, is_load, is_store, is_jal, is_jcond, is_bcond, is_scond;

    assign oper = instr_q[15:12];
    assign rd_f = instr_q[11:8];
    assign func = instr_q[7:4];
    assign rs_f = instr_q[3:0];

    always_comb begin
        illegal  = 1'b0;
        no_wb    = 1'b0;
        is_load  = 1'b0;
        is_store = 1'b0;
        is_jal   = 1'b0;
        is_jcond = 1'b0;
        is_bcond = 1'b0;
        is_scond = 1'b0;
        src_dec  = rf_rdata_b;
        case (oper)
            OpReg: begin
                illegal = (func == 4'b0000) || (func == 4'b1000) || (func == 4'b1100);
                // CMP (1011) and TEST (0100) only update flags
                no_wb   = (func == 4'b1011) || (func == 4'b0100);
            end
            OpSpecial: begin
                case (func)
                    4'b0000: is_load  = 1'b1;
                    4'b0100: is_store = 1'b1;
                    4'b1000: is_jal   = 1'b1;
                    4'b1100: begin
                        is_jcond = 1'b1;
                        no_wb    = 1'b1;
                    end
                    4'b1101: is_scond = 1'b1;
                    default: illegal  = 1'b1;
                endcase
            end
            OpShift: begin
                case (func)
                    4'b0000, 4'b0010: src_dec = {12'b0, rs_f};
                    // right shifts pass a negative amount; the ALU negates it back
                    4'b0001, 4'b0011: src_dec = -{12'b0, rs_f};
                    4'b0100, 4'b0110: src_dec = rf_rdata_b;
                    default:          illegal = 1'b1;
                endcase
            end
            OpBcond: begin
                is_bcond = 1'b1;
                no_wb    = 1'b1;
                src_dec  = {{8{instr_q[7]}}, instr_q[7:0]};
            end
            4'b0001, 4'b0010, 4'b0011, 4'b1101, 4'b1111: src_dec = {8'h00, instr_q[7:0]};
            default: begin
                src_dec = {{8{instr_q[7]}}, instr_q[7:0]};
                no_wb   = (oper == 4'b1011);
            end
        endcase
    end

    assign rf_raddr_a   = rd_f;
    assign rf_raddr_b   = rs_f;
    assign alu_dst      = dst_q;
    assign alu_src      = src_q;
    assign alu_oper     = oper;
    assign alu_func     = func;
    assign alu_cond     = is_scond ? rs_f : rd_f;
    assign alu_psr_read = psr_q;
    assign psr          = psr_q;
    assign mem_addr     = src_q;
    assign mem_wdata    = dst_q;

    always_comb begin
        state_d     = state_q;
        psr_d       = psr_q;
        cnt_d       = cnt_q;
        instr_ready = 1'b0;
        rf_we       = 1'b0;
        rf_waddr    = rd_f;
        rf_wdata    = alu_result;
        pc_load     = 1'b0;
        pc_next     = alu_result;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_err     = 1'b0;
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
        illegal_op  = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                instr_ready = 1'b1;
                if (instr_valid) state_d = StDecode;
            end
            StDecode: begin
                cnt_d   = 8'd0;
                state_d = (is_load || is_store) ? StMem : StExec;
            end
            StExec: begin
                state_d = StIdle;
                if (illegal) begin
`ifdef ALU_EXEC_ILLEGAL_TRAP_EN
                    illegal_op = 1'b1;
                    pc_load    = 1'b1;
                    pc_next    = 16'h0002;
`else
                    pc_load    = 1'b0;
`endif
                end else if (is_jal) begin
                    rf_we    = 1'b1;
                    rf_wdata = pc_q + 16'd1;
                    pc_load  = 1'b1;
                    pc_next  = src_q;
                end else begin
                    psr_d   = (psr_q & ~alu_psr_wr_en) | (alu_psr_write & alu_psr_wr_en);
                    rf_we   = !no_wb;
                    pc_load = is_bcond || is_jcond;
                end
            end
            StMem: begin
                if ((MEM_TIMEOUT != 0) && (cnt_q == TimeoutCnt)) begin
                    mem_err = 1'b1;
                    state_d = StIdle;
                end else begin
                    mem_req = 1'b1;
                    mem_we  = is_store;
                    if (mem_ack) begin
                        rf_we    = is_load;
                        rf_wdata = mem_rdata;
                        state_d  = StIdle;
                    end else if (MEM_TIMEOUT != 0) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            instr_q <= 16'h0000;
            pc_q    <= 16'h0000;
            dst_q   <= 16'h0000;
            src_q   <= 16'h0000;
            psr_q   <= 5'b00000;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            psr_q   <= psr_d;
            cnt_q   <= cnt_d;
            if (state_q == StIdle && instr_valid) begin
                instr_q <= instr;
                pc_q    <= pc;
            end
            if (state_q == StDecode) begin
                dst_q <= is_bcond ? pc_q : rf_rdata_a;
                src_q <= src_dec;
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU, register file and memory around the DUT, with
// directed and randomised instructions checked against an instruction-level reference model.
module tb_alu_exec_ctrl;

    localparam int unsigned MemTimeout = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr, pc;
    logic        instr_valid, instr_ready;
    logic [3:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
    logic [15:0] rf_rdata_a, rf_rdata_b, rf_wdata;
    logic        rf_we;
    logic [15:0] alu_dst, alu_src, alu_result;
    logic [3:0]  alu_oper, alu_func, alu_cond;
    logic [4:0]  alu_psr_read, alu_psr_write, alu_psr_wr_en, psr;
    logic        pc_load;
    logic [15:0] pc_next;
    logic        mem_req, mem_we, mem_ack, mem_err;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;

    logic [15:0] rf [16];
    int          checks = 0;
    int          errors = 0;
    logic [4:0]  exp_psr;
    logic [15:0] last_wdata, last_src, last_pcn;

    alu_exec_ctrl #(.MEM_TIMEOUT(MemTimeout)) dut (
        .clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .pc(pc), .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b),
        .rf_rdata_a(rf_rdata_a), .rf_rdata_b(rf_rdata_b), .rf_we(rf_we), .rf_waddr(rf_waddr),
        .rf_wdata(rf_wdata), .alu_dst(alu_dst), .alu_src(alu_src), .alu_oper(alu_oper),
        .alu_func(alu_func), .alu_cond(alu_cond), .alu_psr_read(alu_psr_read),
        .alu_result(alu_result), .alu_psr_write(alu_psr_write), .alu_psr_wr_en(alu_psr_wr_en),
        .psr(psr), .pc_load(pc_load), .pc_next(pc_next), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    assign rf_rdata_a = rf[rf_raddr_a];
    assign rf_rdata_b = rf[rf_raddr_b];

    // psr bit order {C,L,F,Z,N}
    function automatic logic cond_ok(input logic [3:0] c, input logic [4:0] p);
        case (c)
            4'h0:    return p[1];
            4'h1:    return !p[1];
            4'h2:    return p[4];
            4'h3:    return !p[4];
            4'h4:    return p[3];
            4'h5:    return !p[3];
            4'h6:    return p[0];
            4'h7:    return !p[0];
            4'hE:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic alu_f(input logic [3:0] op, input logic [3:0] fn, input logic [3:0] cnd,
                         input logic [15:0] a, input logic [15:0] b, input logic [4:0] p,
                         output logic [15:0] r, output logic [4:0] w, output logic [4:0] en);
        logic [16:0] s;
        logic [15:0] amt;
        logic [3:0]  k;
        r = 16'h0; w = 5'h0; en = 5'h0; s = 17'h0;
        k = (op == 4'h0) ? fn : op;
        if (op == 4'h8) begin
            amt = b[15] ? -b : b;
            if (!b[15]) r = a << amt;
            else if (fn[1]) r = 16'($signed(a) >>> amt);
            else r = a >> amt;
        end else if (op == 4'hC) begin
            r = cond_ok(cnd, p) ? a + b : a;
        end else if (op == 4'h4) begin
            if (fn == 4'hC) r = cond_ok(cnd, p) ? b : a;
            else if (fn == 4'hD) r = cond_ok(cnd, p) ? 16'h1 : 16'h0;
            else r = a ^ b;
        end else begin
            case (k)
                4'h5, 4'h6, 4'h7: begin
                    s  = {1'b0, a} + {1'b0, b} + ((k == 4'h7) ? {16'h0, p[4]} : 17'h0);
                    r  = s[15:0];
                    w  = {s[16], 1'b0, (a[15] == b[15]) && (r[15] != a[15]), r == 16'h0, r[15]};
                    en = 5'b10111;
                end
                4'h9, 4'hA: begin
                    s  = {1'b0, a} - {1'b0, b};
                    r  = s[15:0];
                    w  = {s[16], 1'b0, (a[15] != b[15]) && (r[15] != a[15]), r == 16'h0, r[15]};
                    en = 5'b10111;
                end
                4'hB: begin
                    r  = a - b;
                    w  = {1'b0, a < b, 2'b00, $signed(a) < $signed(b)};
                    en = 5'b01001;
                end
                4'h1: r = a & b;
                4'h2: r = a | b;
                4'h3: r = a ^ b;
                4'h4: begin
                    r  = a & b;
                    w  = {3'b000, r == 16'h0, 1'b0};
                    en = 5'b00010;
                end
                4'hD: r = b;
                4'hE: r = a * b;
                4'hF: r = (op == 4'hF) ? {b[7:0], 8'h00} : ~a;
                default: r = a ^ b;
            endcase
        end
    endtask

    always_comb begin
        alu_result    = 16'h0;
        alu_psr_write = 5'h0;
        alu_psr_wr_en = 5'h0;
        alu_f(alu_oper, alu_func, alu_cond, alu_dst, alu_src, alu_psr_read,
              alu_result, alu_psr_write, alu_psr_wr_en);
    end

    // Instruction-level reference: what one instruction should do to registers, PC and PSR.
    task automatic model(input logic [15:0] ins, input logic [15:0] pcv, input logic [4:0] p,
                         output logic ill, output logic [15:0] dst, output logic [15:0] src,
                         output logic we, output logic [3:0] waddr, output logic [15:0] wdata,
                         output logic pcl, output logic [15:0] pcn, output logic [4:0] np);
        logic [3:0]  op, fn, rd, rs, cnd;
        logic [15:0] r;
        logic [4:0]  w, en;
        op = ins[15:12]; rd = ins[11:8]; fn = ins[7:4]; rs = ins[3:0];
        ill = (op == 4'h0 && fn inside {4'h0, 4'h8, 4'hC}) ||
              (op == 4'h4 && !(fn inside {4'h0, 4'h4, 4'h8, 4'hC, 4'hD})) ||
              (op == 4'h8 && !(fn inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h6}));
        if (op inside {4'h1, 4'h2, 4'h3, 4'hD, 4'hF}) src = {8'h00, ins[7:0]};
        else if (op inside {4'h5, 4'h6, 4'h7, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE})
            src = 16'($signed(ins[7:0]));
        else if (op == 4'h8 && fn inside {4'h0, 4'h1, 4'h2, 4'h3})
            src = fn[0] ? 16'h0 - 16'(rs) : 16'(rs);
        else src = rf[rs];
        cnd = (op == 4'h4 && fn == 4'hD) ? rs : rd;
        dst = (op == 4'hC) ? pcv : rf[rd];
        alu_f(op, fn, cnd, dst, src, p, r, w, en);
        np = p; we = 1'b0; pcl = 1'b0; waddr = rd; wdata = r; pcn = r;
        if (ill) begin
            we = 1'b0;
        end else if (op == 4'h4 && fn == 4'h8) begin
            we = 1'b1; wdata = pcv + 16'd1; pcl = 1'b1; pcn = rf[rs];
        end else begin
            np  = (p & ~en) | (w & en);
            we  = !((op == 4'h0 && fn inside {4'hB, 4'h4}) || op == 4'hB || op == 4'hC ||
                    (op == 4'h4 && fn == 4'hC));
            pcl = (op == 4'hC) || (op == 4'h4 && fn == 4'hC);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_alu(input logic [15:0] ins, input logic [15:0] pcv);
        logic [15:0] e_dst, e_src, e_wdata, e_pcn;
        logic        e_ill, e_we, e_pcl;
        logic [3:0]  e_waddr;
        logic [4:0]  e_psr;
        model(ins, pcv, exp_psr, e_ill, e_dst, e_src, e_we, e_waddr, e_wdata, e_pcl, e_pcn, e_psr);
        @(negedge clk);
        chk1("ready_idle", instr_ready, 1'b1);
        instr = ins; pc = pcv; instr_valid = 1'b1;
        @(negedge clk);
        // keep offering garbage: a busy controller must not take it
        instr = 16'($urandom); pc = 16'($urandom);
        chk1("ready_busy", instr_ready, 1'b0);
        chk1("dec_rf_we", rf_we, 1'b0);
        chk1("dec_pc_load", pc_load, 1'b0);
        @(negedge clk);
        if (!e_ill) begin
            chk16("alu_dst", alu_dst, e_dst);
            chk16("alu_src", alu_src, e_src);
        end
        chk1("ex_rf_we", rf_we, e_we);
        if (e_we) begin
            chk16("ex_waddr", {12'h0, rf_waddr}, {12'h0, e_waddr});
            chk16("ex_wdata", rf_wdata, e_wdata);
        end
        chk1("ex_pc_load", pc_load, e_pcl);
        if (e_pcl) chk16("ex_pc_next", pc_next, e_pcn);
        chk1("ex_mem_req", mem_req, 1'b0);
        last_wdata = rf_wdata; last_src = alu_src; last_pcn = pc_next;
        @(negedge clk);
        instr_valid = 1'b0;
        chk1("ready_back", instr_ready, 1'b1);
        chk16("psr", {11'h0, psr}, {11'h0, e_psr});
        exp_psr = e_psr;
    endtask

    // ack_at = MEM cycle carrying mem_ack (1-based); 0 = never ack
    task automatic run_mem(input logic [15:0] ins, input int ack_at, input logic [15:0] rdata);
        logic        ld, hit;
        logic [15:0] addr, wd;
        int          ncyc;
        ld = (ins[7:4] == 4'h0); addr = rf[ins[3:0]]; wd = rf[ins[11:8]];
        ncyc = (ack_at == 0) ? MemTimeout : ack_at;
        @(negedge clk);
        chk1("mem_ready_idle", instr_ready, 1'b1);
        instr = ins; pc = 16'($urandom); instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        chk1("mem_dec_req", mem_req, 1'b0);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            hit = (i == ack_at);
            if (hit) begin
                mem_ack = 1'b1; mem_rdata = rdata; #1;
            end
            chk1("mem_req", mem_req, 1'b1);
            chk16("mem_addr", mem_addr, addr);
            chk1("mem_we", mem_we, !ld);
            if (!ld) chk16("mem_wdata", mem_wdata, wd);
            chk1("mem_rf_we", rf_we, ld && hit);
            if (ld && hit) begin
                chk16("mem_waddr", {12'h0, rf_waddr}, {12'h0, ins[11:8]});
                chk16("mem_wdata_rf", rf_wdata, rdata);
            end
            chk1("mem_err_low", mem_err, 1'b0);
        end
        if (ack_at == 0) begin
            @(negedge clk);
            chk1("tmo_req", mem_req, 1'b0);
            chk1("tmo_err", mem_err, 1'b1);
            chk1("tmo_rf_we", rf_we, 1'b0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("mem_done_ready", instr_ready, 1'b1);
        chk1("mem_done_req", mem_req, 1'b0);
        chk1("mem_done_err", mem_err, 1'b0);
        chk16("mem_psr", {11'h0, psr}, {11'h0, exp_psr});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; instr = 16'h0; pc = 16'h0; instr_valid = 1'b0;
        mem_ack = 1'b0; mem_rdata = 16'h0; exp_psr = 5'h0;
        for (int r = 0; r < 16; r++) rf[r] = 16'h0;
        repeat (2) @(negedge clk);
        chk1("rst_ready", instr_ready, 1'b1);
        chk16("rst_psr", {11'h0, psr}, 16'h0);
        chk1("rst_rf_we", rf_we, 1'b0);
        chk1("rst_pc_load", pc_load, 1'b0);
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk1("rst_mem_err", mem_err, 1'b0);
        reset = 1'b0;

        rf[1] = 16'h7FFF; rf[2] = 16'h0001;
        run_alu(16'h0152, 16'h0100);
        chk16("add_wdata", last_wdata, 16'h8000);
        chk16("add_psr", {11'h0, psr}, 16'h0005);

        rf[3] = 16'h0005;
        run_alu(16'hB3FF, 16'h0101);
        chk16("cmpi_psr", {11'h0, psr}, 16'h000C);

        rf[7] = 16'hFFFF; rf[8] = 16'h0001;
        run_alu(16'h0758, 16'h0102);
        chk16("add_zero_psr", {11'h0, psr}, 16'h001A);
        run_alu(16'hC0FE, 16'h0010);
        chk16("beq_taken", last_pcn, 16'h000E);
        run_alu(16'h0152, 16'h0103);
        run_alu(16'hC0FE, 16'h0010);
        chk16("beq_not_taken", last_pcn, 16'h0010);

        rf[4] = 16'h0080;
        run_alu(16'h8413, 16'h0104);
        chk16("lshi_r_src", last_src, 16'hFFFD);
        chk16("lshi_r_wdata", last_wdata, 16'h0010);

        @(negedge clk);
        mem_ack = 1'b1; mem_rdata = 16'h5555; #1;
        chk1("stray_ack_we", rf_we, 1'b0);
        @(negedge clk);
        mem_ack = 1'b0;
        chk1("stray_ack_ready", instr_ready, 1'b1);
        chk1("stray_ack_req", mem_req, 1'b0);

        rf[5] = 16'h0000; rf[6] = 16'h1234;
        run_mem(16'h4506, 4, 16'hBEEF);
        rf[7] = 16'hCAFE;
        run_mem(16'h4746, 0, 16'h0000);

        @(negedge clk);
        instr = 16'h4506; instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        chk1("rstmid_req_before", mem_req, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        chk1("rstmid_req", mem_req, 1'b0);
        chk16("rstmid_psr", {11'h0, psr}, 16'h0);
        chk1("rstmid_ready", instr_ready, 1'b1);
        chk1("rstmid_rf_we", rf_we, 1'b0);
        reset = 1'b0;
        exp_psr = 5'h0;

        for (int n = 0; n < 200; n++) begin
            logic [15:0] ins;
            for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
            ins = 16'($urandom);
            if (ins[15:12] == 4'h4 && (ins[7:4] == 4'h0 || ins[7:4] == 4'h4)) ins[7:4] = 4'h8;
            run_alu(ins, 16'($urandom));
        end
        for (int n = 0; n < 12; n++) begin
            logic [15:0] ins;
            for (int r = 0; r < 16; r++) rf[r] = 16'($urandom);
            ins = 16'($urandom);
            ins[15:12] = 4'h4;
            ins[7:4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'h4;
            run_mem(ins, int'($urandom_range(0, 4)), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Multi-cycle execute-stage sequencer for the 16-bit ALU.
- Accepts one instruction word at a time over a valid/ready handshake.
- Reads operands from the register file, forms immediates and drives the ALU's oper/func/cond/psrRead inputs.
- Owns the 5-bit PSR {C,L,F,Z,N}, writes results back, redirects the PC for jumps/branches, and sequences LOAD/STORE over a req/ack memory port.

Parameters:
MEM_TIMEOUT, 255, max cycles to wait for mem_ack before aborting; 0 = wait forever (8-bit counter).

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
instr  in  16  {oper[15:12], rd/cond[11:8], func/imm[7:4], rs/imm[3:0]}
instr_valid  in  1  instr presented
instr_ready  out  1  controller can accept instr
pc  in  16  address of presented instr
rf_raddr_a / rf_raddr_b  out  4  read addresses (dst=rd, src=rs), combinational read
rf_rdata_a / rf_rdata_b  in  16  read data
rf_we  out  1  write strobe
rf_waddr  out  4  write address
rf_wdata  out  16  write data
alu_dst / alu_src  out  16  ALU operands
alu_oper / alu_func / alu_cond  out  4  ALU controls
alu_psr_read  out  5  current PSR to ALU
alu_result  in  16  ALU result (combinational)
alu_psr_write / alu_psr_wr_en  in  5  ALU flag values / per-bit enables
psr  out  5  architectural PSR {C,L,F,Z,N}
pc_load  out  1  one-cycle strobe: take pc_next
pc_next  out  16  redirect target
mem_req / mem_we  out  1  memory request / write
mem_addr / mem_wdata  out  16  address (rs) / store data (rd)
mem_rdata  in  16  load data
mem_ack  in  1  request complete
mem_err  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset: state=IDLE, instr_ready=1, psr=0, all strobes (rf_we, pc_load, mem_req, mem_we, mem_err) 0, operand/instr regs 0.
- IDLE: instr_ready=1; on instr_valid latch instr and pc, go to DECODE. No acceptance in any other state.
- DECODE: latch rf_rdata_a → dst, build src, then:
  - LOAD/STORE → MEM
  - else → EXEC
- src construction:
  - REGISTER/JCOND/JAL/LSH/ASHU: rf_rdata_b.
  - ANDI/ORI/XORI/MOVI/LUI: zero-extended imm8.
  - ADDI/ADDUI/ADDCI/SUBI/SUBCI/CMPI/MULI/BCOND: sign-extended imm8.
  - LSHI_L/ASHUI_L: {12'b0, imm4}.
  - LSHI_R/ASHUI_R: -{12'b0, imm4}, which the ALU negates back to the shift amount.
- Operand overrides:
  - BCOND: dst = latched pc, cond = instr[11:8].
  - JCOND: cond = instr[11:8].
  - SCOND: cond = instr[3:0], rd = instr[11:8].
- EXEC (1 cycle): drive ALU from latched regs.
  - psr bit i <= alu_psr_write[i] where alu_psr_wr_en[i], else unchanged.
  - rf_we=1, waddr=rd, wdata=alu_result, except CMP/CMPI/TEST/BCOND/JCOND, which do not write back.
  - BCOND/JCOND: pc_load=1, pc_next=alu_result.
  - JAL: rf_wdata = pc+1 to rd, pc_load=1, pc_next = rs value, both in the same cycle.
  - Then → IDLE.
- Latency: ALU instr accepted cycle 0 → rf_we/pc_load/psr update at cycle 2; instr_ready again at cycle 3. Throughput 1 per 3 cycles.
- MEM: mem_req=1 held, mem_addr = rs value, mem_we = STORE, mem_wdata = rd value.
  - On mem_ack: LOAD asserts rf_we (rd ← mem_rdata) that same cycle; then → IDLE.
  - mem_ack outside MEM is ignored.
  - If MEM_TIMEOUT≠0 and the wait counter reaches MEM_TIMEOUT without ack: drop mem_req, pulse mem_err, no writeback, → IDLE.
- psr is never written by LOAD/STORE/JAL.
- Undefined encodings (REGISTER func 0000/1000/1100; SPECIAL funcs other than LOAD/STORE/JAL/JCOND/SCOND; SHIFT func 0101/0111/1xxx) execute as NOP: EXEC with no rf_we, pc_load or psr change.
- reset mid-instruction: abort immediately, no writeback, mem_req drops in the same clock.

Optional Feature:
ALU_EXEC_ILLEGAL_TRAP_EN
- Defined: adds output illegal_op (1 bit). It pulses in EXEC for undefined encodings, and pc_load=1 with pc_next=16'h0002.
- Undefined: no illegal_op port; such encodings are silent NOPs.

Test Plan:
- ADD r1,r2 with r1=0x7FFF, r2=0x0001, psr=0 → cycle 2: rf_we, waddr=1, wdata=0x8000; psr F=1, N=1, Z=0, C=0; instr_ready back at cycle 3.
- CMPI r3,#-1 with r3=0x0005 → no rf_we; psr L and N updated per ALU enables, C/F/Z unchanged from prior.
- BCOND EQ disp 0xFE at pc=0x0010, Z=1 → pc_load, pc_next=0x000E; with Z=0 → pc_next=0x0010; no rf_we either way.
- LSHI_R r4,#3 with r4=0x0080 → alu_src=0xFFFD, wdata=0x0010.
- LOAD r5,[r6] with r6=0x1234, mem_ack after 4 cycles, mem_rdata=0xBEEF → mem_addr=0x1234 held 4 cycles, rf_we with waddr=5, wdata=0xBEEF on the ack cycle.
- STORE with MEM_TIMEOUT=4 and no ack → mem_req for 4 cycles, mem_err pulse, no writes; then assert reset during a pending LOAD → mem_req=0 and psr=0 next cycle, instr_ready=1.
